dcj11_bus_master: RTL and testbench



---
 rtl/dcj11_pkg.sv | 61 ++++++
 rtl/dcj11_bus_master.sv | 205 ++++++++++++++++++++
 tb/tb_dcj11_bus_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcj11_pkg.sv
// dcj11_pkg: shared definitions for the DCJ11-style DAL bus initiator.
//   - AIO cycle-type codes and bank-select codes
//   - bus master state enumeration
//   - AIO classification helpers and the high-address field encoder
`timescale 1ns/1ps
package dcj11_pkg;

  localparam logic [3:0] AIO_NIO        = 4'b1111;
  localparam logic [3:0] AIO_GP_READ    = 4'b1110;
  localparam logic [3:0] AIO_DATA_READ  = 4'b1001;
  localparam logic [3:0] AIO_GP_WRITE   = 4'b0101;
  localparam logic [3:0] AIO_BYTE_WRITE = 4'b0011;
  localparam logic [3:0] AIO_WORD_WRITE = 4'b0001;

  localparam logic [1:0] BS_MEM = 2'b00;
  localparam logic [1:0] BS_SYS = 2'b01;
  localparam logic [1:0] BS_EXT = 2'b10;
  localparam logic [1:0] BS_INT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_AH,
    ST_STRB,
    ST_RD,
    ST_REC
  } state_t;

  // 1xxx except 1111 is a read of some flavour.
  function automatic logic is_read_code(input logic [3:0] aio);
    return aio[3] && (aio != AIO_NIO);
  endfunction

  // 0xx1 is a write; 0xx0 codes have no data transfer and run like NIO.
  function automatic logic is_write_code(input logic [3:0] aio);
    return !aio[3] && aio[0];
  endfunction

  function automatic logic is_gp_code(input logic [3:0] aio);
    return (aio == AIO_GP_READ) || (aio == AIO_GP_WRITE);
  endfunction

  // Second address phase: A21..A16 and BS scattered onto the DAL bit
  // positions the responder decodes; every other bit is driven low.
  function automatic logic [15:0] hi_addr_field(input logic [21:0] addr,
                                                input logic [1:0]  bs);
    logic [15:0] f;
    f     = '0;
    f[8]  = addr[21];
    f[0]  = addr[20];
    f[9]  = addr[19];
    f[10] = addr[18];
    f[11] = addr[17];
    f[12] = addr[16];
    f[6]  = bs[0];
    f[7]  = bs[1];
    return f;
  endfunction

endpackage

// File: rtl/dcj11_bus_master.sv
// dcj11_bus_master: single-request initiator for the multiplexed DAL bus.
// Turns one command (AIO, BS, 22-bit address, write data) into the
// ALE / SCTL / BUFCTL sequence A0 -> A1 -> AH -> STRB -> [RD] -> REC.
// Ports:
//   clk_x3, rstb                 54 MHz clock, synchronous active-high reset
//   req_valid/req_ready          command handshake
//   req_aio/req_bs/req_addr/req_wdata  command fields
//   rsp_valid/rsp_rdata/rsp_nxm  one-cycle completion with read data / abort
//   ale_n/sctl_n/bufctl_n/aio_o  bus control
//   dal_o/dal_oe/dal_i           DAL drive, enable and sample
//   nxm_n/cont_n                 responder abort and wait-state inputs
`timescale 1ns/1ps
module dcj11_bus_master
  import dcj11_pkg::*;
#(
  parameter int unsigned ADDR_HOLD = 1,
  parameter int unsigned STRB_CYC  = 3,
  parameter int unsigned RECOV_CYC = 2,
  parameter int unsigned WAIT_MAX  = 255
) (
  input  logic        clk_x3,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_aio,
  input  logic [1:0]  req_bs,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_nxm,
  output logic        ale_n,
  output logic        sctl_n,
  output logic        bufctl_n,
  output logic [3:0]  aio_o,
  output logic [15:0] dal_o,
  output logic        dal_oe,
  input  logic [15:0] dal_i,
  input  logic        nxm_n,
  input  logic        cont_n
);

  localparam logic [15:0] AH_N   = 16'(ADDR_HOLD);
  localparam logic [15:0] STRB_N = 16'(STRB_CYC);
  localparam logic [15:0] REC_N  = 16'(RECOV_CYC);
  localparam logic [15:0] WAIT_N = 16'(WAIT_MAX);

  state_t      state;
  logic [3:0]  cmd_aio;
  logic [15:0] cmd_hi;     // pre-encoded high-address field
  logic [15:0] cmd_wdata;  // already byte-replicated for byte writes
  logic [15:0] cnt;        // phase length counter (AH, STRB, REC)
  logic [15:0] wait_cnt;   // cont_n-high cycles in the current strobe
  logic        strb_abort;
  logic        strb_done;

  // A wait cycle that brings the count to WAIT_MAX aborts like nxm.
  always_comb begin
    strb_abort = !nxm_n || (cont_n && ((wait_cnt + 16'd1) >= WAIT_N));
    strb_done  = !cont_n && (cnt >= STRB_N);
  end

  // Outputs are assigned on the edge that enters each state, so every
  // entry into REC repeats the same strobe-release block.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nxm   <= 1'b0;
      ale_n     <= 1'b1;
      sctl_n    <= 1'b1;
      bufctl_n  <= 1'b1;
      aio_o     <= '1;
      dal_o     <= '0;
      dal_oe    <= 1'b0;
      cmd_aio   <= '1;
      cmd_hi    <= '0;
      cmd_wdata <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_nxm   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            cmd_aio   <= req_aio;
            cmd_hi    <= hi_addr_field(req_addr, req_bs);
            cmd_wdata <= (req_aio == AIO_BYTE_WRITE) ?
                         {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            ale_n     <= 1'b0;
            dal_oe    <= 1'b1;
            aio_o     <= req_aio;
            dal_o     <= is_gp_code(req_aio) ? {8'h00, req_addr[7:0]}
                                             : req_addr[15:0];
            state     <= ST_A0;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_A0: begin
          dal_o <= cmd_hi;
          state <= ST_A1;
        end

        ST_A1: begin
          cnt   <= 16'd1;
          state <= ST_AH;
        end

        ST_AH: begin
          if (cnt >= AH_N) begin
            cnt      <= 16'd1;
            wait_cnt <= '0;
            if (is_write_code(cmd_aio)) begin
              sctl_n <= 1'b0;
              dal_o  <= cmd_wdata;
              state  <= ST_STRB;
            end else if (is_read_code(cmd_aio)) begin
              sctl_n   <= 1'b0;
              bufctl_n <= 1'b0;
              dal_oe   <= 1'b0;
              dal_o    <= '0;
              state    <= ST_STRB;
            end else begin
              ale_n     <= 1'b1;
              dal_oe    <= 1'b0;
              dal_o     <= '0;
              aio_o     <= '1;
              rsp_valid <= 1'b1;
              state     <= ST_REC;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_STRB: begin
          if (strb_abort) begin
            ale_n     <= 1'b1;
            sctl_n    <= 1'b1;
            bufctl_n  <= 1'b1;
            dal_oe    <= 1'b0;
            dal_o     <= '0;
            aio_o     <= '1;
            rsp_valid <= 1'b1;
            rsp_nxm   <= 1'b1;
            rsp_rdata <= '0;
            cnt       <= 16'd1;
            state     <= ST_REC;
          end else if (strb_done) begin
            if (is_read_code(cmd_aio)) begin
              // bufctl_n stays low so the responder still drives DAL in RD
              sctl_n <= 1'b1;
              state  <= ST_RD;
            end else begin
              ale_n     <= 1'b1;
              sctl_n    <= 1'b1;
              bufctl_n  <= 1'b1;
              dal_oe    <= 1'b0;
              dal_o     <= '0;
              aio_o     <= '1;
              rsp_valid <= 1'b1;
              cnt       <= 16'd1;
              state     <= ST_REC;
            end
          end else begin
            if (cnt < STRB_N) cnt <= cnt + 16'd1;
            if (cont_n) wait_cnt <= wait_cnt + 16'd1;
          end
        end

        ST_RD: begin
          rsp_rdata <= dal_i;
          ale_n     <= 1'b1;
          sctl_n    <= 1'b1;
          bufctl_n  <= 1'b1;
          dal_oe    <= 1'b0;
          dal_o     <= '0;
          aio_o     <= '1;
          rsp_valid <= 1'b1;
          cnt       <= 16'd1;
          state     <= ST_REC;
        end

        ST_REC: begin
          if (cnt >= REC_N) begin
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcj11_bus_master.sv
// tb_dcj11_bus_master: directed table, reset-abort sequence and randomized
// transactions for dcj11_bus_master. Expected bus activity is derived per
// transaction from phase lengths computed arithmetically from the cycle rules.
`timescale 1ns/1ps
module tb_dcj11_bus_master;
  import dcj11_pkg::*;

  localparam int unsigned ADDR_HOLD_TB = 1;
  localparam int unsigned STRB_CYC_TB  = 3;
  localparam int unsigned RECOV_CYC_TB = 2;
  localparam int unsigned WAIT_MAX_TB  = 12;

  logic        clk_x3 = 1'b0;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_aio;
  logic [1:0]  req_bs;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_nxm;
  logic        ale_n, sctl_n, bufctl_n, dal_oe;
  logic [3:0]  aio_o;
  logic [15:0] dal_o, dal_i;
  logic        nxm_n, cont_n;

  int total = 0;
  int bad   = 0;

  dcj11_bus_master #(
    .ADDR_HOLD (ADDR_HOLD_TB),
    .STRB_CYC  (STRB_CYC_TB),
    .RECOV_CYC (RECOV_CYC_TB),
    .WAIT_MAX  (WAIT_MAX_TB)
  ) dut (
    .clk_x3    (clk_x3),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_aio   (req_aio),
    .req_bs    (req_bs),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nxm   (rsp_nxm),
    .ale_n     (ale_n),
    .sctl_n    (sctl_n),
    .bufctl_n  (bufctl_n),
    .aio_o     (aio_o),
    .dal_o     (dal_o),
    .dal_oe    (dal_oe),
    .dal_i     (dal_i),
    .nxm_n     (nxm_n),
    .cont_n    (cont_n)
  );

  always #9 clk_x3 = ~clk_x3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  aio;
    logic [1:0]  bs;
    logic [21:0] addr;
    logic [15:0] wdata;
    int unsigned w;       // cont_n-high cycles at the start of STRB
    int unsigned k;       // STRB cycle with nxm_n low, 0 = never
    logic [15:0] rdata;   // responder read data
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    logic        exp_nxm;
    logic [15:0] exp_rd;
    int unsigned exp_len; // cycles from accept cycle (1) to rsp_valid
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk_x3);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input string ph, input logic e_ale, input logic e_sctl,
                         input logic e_buf, input logic e_oe,
                         input logic [15:0] e_dal, input logic [3:0] e_aio);
    chk({ph, ".ale_n"},    32'(ale_n),    32'(e_ale));
    chk({ph, ".sctl_n"},   32'(sctl_n),   32'(e_sctl));
    chk({ph, ".bufctl_n"}, 32'(bufctl_n), 32'(e_buf));
    chk({ph, ".dal_oe"},   32'(dal_oe),   32'(e_oe));
    if (e_oe) chk({ph, ".dal_o"}, 32'(dal_o), 32'(e_dal));
    chk({ph, ".aio_o"},    32'(aio_o),    32'(e_aio));
  endtask

  task automatic chk_reset(input string tag);
    exp_bus(tag, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'hF);
    chk({tag, ".dal_o"},     32'(dal_o),     32'h0);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'h0);
    chk({tag, ".rsp_nxm"},   32'(rsp_nxm),   32'h0);
  endtask

  // Strobe length from the rules: normal end is the first cycle that is both
  // past STRB_CYC and has cont_n low; an nxm cycle or the WAIT_MAX-th wait
  // cycle ends it early.
  task automatic strb_plan(input int unsigned w, input int unsigned k,
                           output int unsigned len, output bit abort);
    int unsigned norm, ab;
    norm = (w + 1 > STRB_CYC_TB) ? w + 1 : STRB_CYC_TB;
    ab   = 0;
    if (w >= WAIT_MAX_TB) ab = WAIT_MAX_TB;
    if (k != 0 && (ab == 0 || k < ab)) ab = k;
    if (ab != 0 && ab <= norm) begin
      len = ab; abort = 1'b1;
    end else begin
      len = norm; abort = 1'b0;
    end
  endtask

  // Entered on the first cycle of IDLE (req_ready expected high); returns on
  // the next such cycle.
  task automatic run_txn(input logic [3:0] aio, input logic [1:0] bs,
                         input logic [21:0] addr, input logic [15:0] wdata,
                         input int unsigned w, input int unsigned k,
                         input logic [15:0] rdata,
                         output logic [15:0] cap_a0, output logic [15:0] cap_a1,
                         output logic cap_nxm, output logic [15:0] cap_rd,
                         output int unsigned cap_len);
    bit rd, wr, gp, abort;
    int unsigned slen, n;
    logic [15:0] a0, a1, wv, rexp;
    rd = aio[3] && (aio != 4'hF);
    wr = !aio[3] && aio[0];
    gp = (aio == 4'hE) || (aio == 4'h5);
    a0 = gp ? {8'h00, addr[7:0]} : addr[15:0];
    a1 = '0;
    a1[8] = addr[21]; a1[0] = addr[20]; a1[9] = addr[19];
    a1[10] = addr[18]; a1[11] = addr[17]; a1[12] = addr[16];
    a1[6] = bs[0]; a1[7] = bs[1];
    wv = (aio == 4'h3) ? {wdata[7:0], wdata[7:0]} : wdata;
    strb_plan(w, k, slen, abort);
    if (!(rd || wr)) begin slen = 0; abort = 1'b0; end
    rexp = abort ? 16'h0 : rdata;
    cap_a0 = '0; cap_a1 = '0; cap_nxm = 1'b0; cap_rd = '0; cap_len = 0;

    chk("idle.req_ready", 32'(req_ready), 32'h1);
    chk("idle.rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b1; req_aio = aio; req_bs = bs; req_addr = addr; req_wdata = wdata;
    cont_n = 1'b0; nxm_n = 1'b1;
    n = 1;
    step();
    // fields scrambled while busy: the latched command must be used
    req_valid = 1'($urandom_range(0, 1));
    req_aio = 4'($urandom); req_bs = 2'($urandom);
    req_addr = 22'($urandom); req_wdata = 16'($urandom);

    n++;
    exp_bus("A0", 1'b0, 1'b1, 1'b1, 1'b1, a0, aio);
    chk("A0.req_ready", 32'(req_ready), 32'h0);
    chk("A0.rsp_valid", 32'(rsp_valid), 32'h0);
    cap_a0 = dal_o;
    step();
    for (int unsigned i = 0; i <= ADDR_HOLD_TB; i++) begin
      n++;
      exp_bus((i == 0) ? "A1" : "AH", 1'b0, 1'b1, 1'b1, 1'b1, a1, aio);
      chk("A1.rsp_valid", 32'(rsp_valid), 32'h0);
      if (i == 0) cap_a1 = dal_o;
      step();
    end
    for (int unsigned s = 1; s <= slen; s++) begin
      cont_n = (s <= w);
      nxm_n  = (s != k);
      dal_i  = rd ? rdata : 16'($urandom);
      n++;
      exp_bus("STRB", 1'b0, 1'b0, !rd, wr, wv, aio);
      chk("STRB.rsp_valid", 32'(rsp_valid), 32'h0);
      step();
    end
    cont_n = 1'b0; nxm_n = 1'b1;
    if (rd && !abort) begin
      dal_i = rdata;
      n++;
      exp_bus("RD", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, aio);
      chk("RD.rsp_valid", 32'(rsp_valid), 32'h0);
      step();
    end
    dal_i = 16'($urandom);
    for (int unsigned r = 1; r <= RECOV_CYC_TB; r++) begin
      n++;
      exp_bus("REC", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'hF);
      chk("REC.rsp_valid", 32'(rsp_valid), (r == 1) ? 32'h1 : 32'h0);
      if (r == 1) begin
        cap_len = n; cap_nxm = rsp_nxm; cap_rd = rsp_rdata;
        chk("rsp.nxm", 32'(rsp_nxm), 32'(abort));
        if (rd) chk("rsp.rdata", 32'(rsp_rdata), 32'(rexp));
      end
      if (r == RECOV_CYC_TB) req_valid = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [15:0] ca0, ca1, crd;
    logic cnxm;
    int unsigned clen;
    logic [3:0] raio;

    rstb = 1'b1; req_valid = 1'b0; req_aio = 4'hF; req_bs = '0;
    req_addr = '0; req_wdata = '0; dal_i = '0; nxm_n = 1'b1; cont_n = 1'b0;
    step(); step();
    chk_reset("por");
    rstb = 1'b0;
    step();

    //          aio             bs      addr          wdata       w   k  rdata     a0        a1        nxm   rd       len
    vecs[0]  = '{AIO_WORD_WRITE, BS_MEM, 22'o001000,   16'o123456, 0,  0, 16'h0,    16'h0200, 16'h0000, 1'b0, 16'h0,    8};
    vecs[1]  = '{AIO_DATA_READ,  BS_EXT, 22'o17777564, 16'h0,      0,  0, 16'h0080, 16'hFF74, 16'h1F81, 1'b0, 16'h0080, 9};
    vecs[2]  = '{AIO_DATA_READ,  BS_MEM, 22'o17760000, 16'h0,      0,  2, 16'h1234, 16'hE000, 16'h1F01, 1'b1, 16'h0,    7};
    vecs[3]  = '{AIO_WORD_WRITE, BS_MEM, 22'o000000,   16'hBEEF,   10, 0, 16'h0,    16'h0000, 16'h0000, 1'b0, 16'h0,    16};
    vecs[4]  = '{AIO_DATA_READ,  BS_MEM, 22'o000200,   16'h0,      14, 0, 16'h5A5A, 16'h0080, 16'h0000, 1'b1, 16'h0,    17};
    vecs[5]  = '{AIO_WORD_WRITE, BS_MEM, 22'o000002,   16'h0F0F,   11, 0, 16'h0,    16'h0002, 16'h0000, 1'b0, 16'h0,    17};
    vecs[6]  = '{AIO_GP_READ,    BS_MEM, 22'o000000,   16'h0,      0,  0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16'h0003, 9};
    vecs[7]  = '{AIO_BYTE_WRITE, BS_MEM, 22'o000001,   16'h12AB,   0,  0, 16'h0,    16'h0001, 16'h0000, 1'b0, 16'h0,    8};
    vecs[8]  = '{AIO_NIO,        BS_MEM, 22'o000010,   16'h0,      0,  0, 16'h0,    16'h0008, 16'h0000, 1'b0, 16'h0,    5};
    vecs[9]  = '{AIO_GP_WRITE,   BS_INT, 22'h3F00AA,   16'hC3C3,   0,  0, 16'h0,    16'h00AA, 16'h1FC1, 1'b0, 16'h0,    8};
    vecs[10] = '{AIO_WORD_WRITE, BS_SYS, 22'o000004,   16'h7777,   0,  1, 16'h0,    16'h0004, 16'h0040, 1'b1, 16'h0,    6};
    vecs[11] = '{AIO_DATA_READ,  BS_MEM, 22'o000006,   16'h0,      0,  3, 16'hFFFF, 16'h0006, 16'h0000, 1'b1, 16'h0,    8};

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].aio, vecs[i].bs, vecs[i].addr, vecs[i].wdata, vecs[i].w,
              vecs[i].k, vecs[i].rdata, ca0, ca1, cnxm, crd, clen);
      chk($sformatf("vec%0d.a0", i),  32'(ca0),  32'(vecs[i].exp_a0));
      chk($sformatf("vec%0d.a1", i),  32'(ca1),  32'(vecs[i].exp_a1));
      chk($sformatf("vec%0d.nxm", i), 32'(cnxm), 32'(vecs[i].exp_nxm));
      chk($sformatf("vec%0d.len", i), clen,      vecs[i].exp_len);
      if (vecs[i].aio[3] && vecs[i].aio != 4'hF)
        chk($sformatf("vec%0d.rdata", i), 32'(crd), 32'(vecs[i].exp_rd));
    end

    // reset in the second strobe cycle of a write
    req_valid = 1'b1; req_aio = AIO_WORD_WRITE; req_bs = BS_MEM;
    req_addr = 22'o000100; req_wdata = 16'h5555; cont_n = 1'b0; nxm_n = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    chk("rstmid.sctl_pre", 32'(sctl_n), 32'h0);
    step();
    rstb = 1'b1;
    step();
    chk_reset("rstmid");
    rstb = 1'b0;
    step();
    chk("rstmid.no_rsp", 32'(rsp_valid), 32'h0);
    run_txn(AIO_DATA_READ, BS_SYS, 22'o000300, 16'h0, 1, 0, 16'hA1B2,
            ca0, ca1, cnxm, crd, clen);
    chk("postrst.rdata", 32'(crd), 32'hA1B2);
    chk("postrst.len",   clen,     32'd9);

    for (int i = 0; i < 60; i++) begin
      raio = 4'($urandom);
      run_txn(raio, 2'($urandom), 22'($urandom), 16'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 14) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
              16'($urandom), ca0, ca1, cnxm, crd, clen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
